// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;
  typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_BR = 2'b01, PC_J = 2'b10} pcSel_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwdSel_t;
  typedef enum logic [1:0] {RUN, WAIT, DONE} memState_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-status inputs and stall/flush/forward outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegM, WriteRegW;
  logic       MemToRegE, RegWriteM, MemToRegM, MemWriteM;
  logic       BranchEqM, zeroM, JumpM, RegWriteW;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE, PCctrl;
  logic [CNT_W-1:0] stall_cycles, redirects;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegM, WriteRegW,
           MemToRegE, RegWriteM, MemToRegM, MemWriteM,
           BranchEqM, zeroM, JumpM, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, PCctrl, stall_cycles, redirects
  );
  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegM, WriteRegW,
           MemToRegE, RegWriteM, MemToRegM, MemWriteM,
           BranchEqM, zeroM, JumpM, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, PCctrl, stall_cycles, redirects
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EXE operand forwarding select for one source register; MEM result beats WB.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       regWriteM,
  input  logic [4:0] writeRegM,
  input  logic       regWriteW,
  input  logic [4:0] writeRegW,
  output fwdSel_t    sel
);
  always_comb begin
    sel = FWD_RF;
    // $0 is hardwired, so a write to it never produces a forwardable value
    if (regWriteM && writeRegM != 5'd0 && writeRegM == rs)      sel = FWD_MEM;
    else if (regWriteW && writeRegW != 5'd0 && writeRegW == rs) sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: data-memory wait sequencing, redirect/load-use priority,
// EXE forwarding selects and stall/redirect counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DM_LAT = 2,
  parameter int CNT_W  = 32
) (
  input logic clk,
  input logic clr,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int CW = (DM_LAT > 1) ? $clog2(DM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((DM_LAT > 0) ? DM_LAT - 1 : 0);

  memState_t state, nextState;
  logic [CW-1:0] cnt, nextCnt;
  logic memOp, hold, take, takeOk, lwStall, lwOk, stallF;
  fwdSel_t fwdA, fwdB;
  logic [CNT_W-1:0] stallCnt, redirCnt;

  assign memOp = bus.MemToRegM | bus.MemWriteM;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // DONE lets the held memory op retire without re-arming, even if memOp stays high
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    hold      = 1'b0;
    case (state)
      RUN: if (memOp && DM_LAT > 0) begin
        hold      = 1'b1;
        nextCnt   = CNT_INIT;
        nextState = (DM_LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        hold    = 1'b1;
        nextCnt = cnt - 1'b1;
        if (cnt == CW'(1)) nextState = DONE;
      end
      DONE:    nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  assign take    = (bus.BranchEqM & bus.zeroM) | bus.JumpM;
  assign takeOk  = ~hold & take;
  assign lwStall = bus.MemToRegE && (bus.RtE != 5'd0) &&
                   (bus.RtE == bus.RsD || bus.RtE == bus.RtD);
  // a taken redirect squashes the dependent instruction, so no load-use bubble
  assign lwOk    = ~hold & ~take & lwStall;
  assign stallF  = hold | lwOk;

  fwd_unit uFwdA (
    .rs(bus.RsE), .regWriteM(bus.RegWriteM), .writeRegM(bus.WriteRegM),
    .regWriteW(bus.RegWriteW), .writeRegW(bus.WriteRegW), .sel(fwdA)
  );
  fwd_unit uFwdB (
    .rs(bus.RtE), .regWriteM(bus.RegWriteM), .writeRegM(bus.WriteRegM),
    .regWriteW(bus.RegWriteW), .writeRegW(bus.WriteRegW), .sel(fwdB)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stallCnt <= '0;
      redirCnt <= '0;
    end else begin
      if (stallF) stallCnt <= stallCnt + 1'b1;
      if (takeOk) redirCnt <= redirCnt + 1'b1;
    end
  end

  assign bus.StallF       = ~clr & stallF;
  assign bus.StallD       = ~clr & stallF;
  assign bus.StallE       = ~clr & hold;
  assign bus.StallM       = ~clr & hold;
  assign bus.FlushD       = ~clr & takeOk;
  assign bus.FlushE       = ~clr & (takeOk | lwOk);
  assign bus.FlushM       = ~clr & takeOk;
  assign bus.FlushW       = ~clr & hold;
  assign bus.ForwardAE    = clr ? FWD_RF : fwdA;
  assign bus.ForwardBE    = clr ? FWD_RF : fwdB;
  assign bus.PCctrl       = (clr || !takeOk) ? PC_SEQ : (bus.JumpM ? PC_J : PC_BR);
  assign bus.stall_cycles = stallCnt;
  assign bus.redirects    = redirCnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (DM_LAT 0/2/3) on shared stimulus,
// a per-cycle behavioural model plus hand-computed directed expectations.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic sF, sD, sE, sM, fD, fE, fM, fW;
    logic [1:0] fa, fb, pc;
    logic [CNT_W-1:0] sc, rd;
  } outs_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegM, WriteRegW;
  logic MemToRegE, RegWriteM, MemToRegM, MemWriteM, BranchEqM, zeroM, JumpM, RegWriteW;
  outs_t outs [3];

  int total = 0, passed = 0;
  bit checkOn = 0;

  always #5 clk = ~clk;

  function automatic int latOf(int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gDut
    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    assign bus.RsD = RsD;             assign bus.RtD = RtD;
    assign bus.RsE = RsE;             assign bus.RtE = RtE;
    assign bus.WriteRegM = WriteRegM; assign bus.WriteRegW = WriteRegW;
    assign bus.MemToRegE = MemToRegE; assign bus.RegWriteM = RegWriteM;
    assign bus.MemToRegM = MemToRegM; assign bus.MemWriteM = MemWriteM;
    assign bus.BranchEqM = BranchEqM; assign bus.zeroM = zeroM;
    assign bus.JumpM = JumpM;         assign bus.RegWriteW = RegWriteW;
    assign outs[g] = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                      bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW,
                      bus.ForwardAE, bus.ForwardBE, bus.PCctrl,
                      bus.stall_cycles, bus.redirects};
    pipe_hazard_ctrl #(.DM_LAT((g == 0) ? 0 : (g == 1) ? 2 : 3), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .bus(bus)
    );
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask

  function automatic logic [1:0] fwdExp(logic [4:0] r);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == r) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == r) return 2'b01;
    return 2'b00;
  endfunction

  // model: remaining hold cycles per memory op, and whether the op just retired
  int rem [3];
  bit done [3];
  logic [CNT_W-1:0] mSc [3], mRd [3];

  always @(negedge clk) if (checkOn) begin
    for (int i = 0; i < 3; i++) begin
      outs_t e;
      bit hold, tk, lwOk;
      e = '0; hold = 0; tk = 0; lwOk = 0;
      if (clr) begin
        rem[i] = 0; done[i] = 0; mSc[i] = '0; mRd[i] = '0;
      end else begin
        hold = rem[i] > 0 || (!done[i] && (MemToRegM || MemWriteM) && latOf(i) > 0);
        tk   = !hold && ((BranchEqM && zeroM) || JumpM);
        lwOk = !hold && !((BranchEqM && zeroM) || JumpM) &&
               MemToRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
        e.sF = hold || lwOk; e.sD = e.sF; e.sE = hold; e.sM = hold; e.fW = hold;
        e.fD = tk; e.fM = tk; e.fE = tk || lwOk;
        e.pc = !tk ? 2'b00 : JumpM ? 2'b10 : 2'b01;
        e.fa = fwdExp(RsE); e.fb = fwdExp(RtE);
        e.sc = mSc[i]; e.rd = mRd[i];
      end
      chk($sformatf("u%0d.StallF", i), 32'(outs[i].sF), 32'(e.sF));
      chk($sformatf("u%0d.StallD", i), 32'(outs[i].sD), 32'(e.sD));
      chk($sformatf("u%0d.StallE", i), 32'(outs[i].sE), 32'(e.sE));
      chk($sformatf("u%0d.StallM", i), 32'(outs[i].sM), 32'(e.sM));
      chk($sformatf("u%0d.FlushD", i), 32'(outs[i].fD), 32'(e.fD));
      chk($sformatf("u%0d.FlushE", i), 32'(outs[i].fE), 32'(e.fE));
      chk($sformatf("u%0d.FlushM", i), 32'(outs[i].fM), 32'(e.fM));
      chk($sformatf("u%0d.FlushW", i), 32'(outs[i].fW), 32'(e.fW));
      chk($sformatf("u%0d.ForwardAE", i), 32'(outs[i].fa), 32'(e.fa));
      chk($sformatf("u%0d.ForwardBE", i), 32'(outs[i].fb), 32'(e.fb));
      chk($sformatf("u%0d.PCctrl", i), 32'(outs[i].pc), 32'(e.pc));
      chk($sformatf("u%0d.stall_cycles", i), 32'(outs[i].sc), 32'(e.sc));
      chk($sformatf("u%0d.redirects", i), 32'(outs[i].rd), 32'(e.rd));
      if (!clr) begin
        if (e.sF) mSc[i] = mSc[i] + 1'b1;
        if (tk)   mRd[i] = mRd[i] + 1'b1;
        if (rem[i] > 0) begin
          rem[i]--; done[i] = (rem[i] == 0);
        end else if (hold) begin
          rem[i] = latOf(i) - 1; done[i] = (rem[i] == 0);
        end else done[i] = 0;
      end
    end
  end

  task automatic idle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegM = 0; WriteRegW = 0;
    MemToRegE = 0; RegWriteM = 0; MemToRegM = 0; MemWriteM = 0;
    BranchEqM = 0; zeroM = 0; JumpM = 0; RegWriteW = 0;
  endtask
  task automatic nx();  @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  initial begin
    idle(); checkOn = 1;
    // forwarding must be masked while reset is held
    RegWriteM = 1; WriteRegM = 8; RsE = 8;
    smp();
    chk("rst.ForwardAE", 32'(outs[0].fa), 0);
    chk("rst.stall_cycles", 32'(outs[2].sc), 0);
    nx(); idle(); smp();
    nx(); clr = 0; smp();

    nx(); RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8; RtE = 5; smp();
    chk("fwd.mem_prio", 32'(outs[0].fa), 2); chk("fwd.no_match_B", 32'(outs[0].fb), 0);
    nx(); RegWriteM = 0; smp();
    chk("fwd.wb", 32'(outs[0].fa), 1);
    nx(); RegWriteM = 1; WriteRegM = 0; RsE = 0; WriteRegW = 5; RtE = 5; smp();
    chk("fwd.r0", 32'(outs[0].fa), 0); chk("fwd.wb_B", 32'(outs[0].fb), 1);

    nx(); idle(); MemToRegE = 1; RtE = 9; RtD = 9; smp();
    chk("lw.StallF", 32'(outs[0].sF), 1); chk("lw.FlushE", 32'(outs[0].fE), 1);
    chk("lw.cnt_before", 32'(outs[0].sc), 0);
    nx(); idle(); smp();
    chk("lw.release", 32'(outs[0].sF), 0); chk("lw.cnt_after", 32'(outs[0].sc), 1);

    nx(); MemToRegE = 1; RtE = 9; RsD = 9; BranchEqM = 1; zeroM = 1; smp();
    chk("br.PCctrl", 32'(outs[0].pc), 1); chk("br.StallF", 32'(outs[0].sF), 0);
    chk("br.FlushD", 32'(outs[0].fD), 1); chk("br.redir_before", 32'(outs[0].rd), 0);
    nx(); JumpM = 1; smp();
    chk("jmp.PCctrl", 32'(outs[0].pc), 2); chk("jmp.redir", 32'(outs[0].rd), 1);
    nx(); idle(); smp();
    chk("br.redir_total", 32'(outs[0].rd), 2); chk("br.stall_total", 32'(outs[0].sc), 1);

    for (int k = 0; k < 4; k++) begin
      nx(); idle(); MemToRegM = 1; smp();
      chk($sformatf("lat3.hold%0d", k), 32'(outs[2].sF), (k < 3) ? 1 : 0);
      chk($sformatf("lat3.FlushW%0d", k), 32'(outs[2].fW), (k < 3) ? 1 : 0);
    end
    nx(); idle(); smp();
    chk("lat3.stall_cycles", 32'(outs[2].sc), 4);
    nx(); smp();

    nx(); MemToRegM = 1; smp();
    nx(); smp();
    chk("abort.in_wait", 32'(outs[2].sF), 1);
    nx(); clr = 1; smp();
    chk("abort.StallF", 32'(outs[2].sF), 0); chk("abort.FlushW", 32'(outs[2].fW), 0);
    chk("abort.cnt", 32'(outs[2].sc), 0);
    nx(); clr = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) nx();
      smp();
      chk($sformatf("fresh.hold%0d", k), 32'(outs[2].sF), (k < 3) ? 1 : 0);
    end
    nx(); idle(); smp();
    chk("fresh.stall_cycles", 32'(outs[2].sc), 3);

    nx(); clr = 1; smp();
    nx(); clr = 0; smp();
    for (int k = 0; k < 6; k++) begin
      nx(); idle(); MemWriteM = 1; smp();
      chk($sformatf("st2.hold%0d", k), 32'(outs[1].sF), (k % 3 != 2) ? 1 : 0);
    end
    nx(); idle(); smp();
    chk("st2.stall_cycles", 32'(outs[1].sc), 4);
    repeat (3) begin nx(); smp(); end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
